// File: rtl/rv32_pkg.sv
// Shared rv32 pipeline types and constants used by the hazard controller.
package rv32_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_FWD    = 2;
    localparam int FWD_SEL_W  = $clog2(NUM_FWD + 1);

    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_DRAIN = 1'b1
    } hazard_state_e;

    // Saturating 32-bit increment for the performance counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        logic [31:0] res;
        if (val == 32'hFFFF_FFFF) begin
            res = val;
        end else begin
            res = val + 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-register scoreboard for multi-cycle results (loads, mul/div).
// Produces the effective pending set that already reflects this cycle's issue/done.
module hazard_scoreboard #(
    parameter  int REG_ADDR_W = 5,
    localparam int NREG       = 2 ** REG_ADDR_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  issue_i,
    input  logic [REG_ADDR_W-1:0] issue_rd_i,
    input  logic                  done_i,
    input  logic [REG_ADDR_W-1:0] done_rd_i,
    output logic [NREG-1:0]       sb_eff_o,
    output logic [NREG-1:0]       sb_pending_o,
    output logic                  empty_o
);

    logic [NREG-1:0] sb_q;
    logic [NREG-1:0] sb_d;
    logic [NREG-1:0] issue_mask_s;
    logic [NREG-1:0] done_mask_s;

    // Set beats clear so a result retiring as the same rd re-issues stays pending.
    always_comb begin
        issue_mask_s = '0;
        done_mask_s  = '0;
        if (issue_i) begin
            issue_mask_s[issue_rd_i] = 1'b1;
        end else begin
            issue_mask_s = '0;
        end
        if (done_i) begin
            done_mask_s[done_rd_i] = 1'b1;
        end else begin
            done_mask_s = '0;
        end
        sb_d    = (sb_q & ~done_mask_s) | issue_mask_s;
        sb_d[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign sb_eff_o     = sb_d;
    assign sb_pending_o = sb_q;
    assign empty_o      = (sb_d == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// rv32 hazard controller: operand forwarding, load-use/scoreboard stalls and fence drain.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import rv32_pkg::*;
#(
    parameter  int NUM_FWD    = 2,
    parameter  int REG_ADDR_W = 5,
    localparam int FWD_SEL_W  = $clog2(NUM_FWD + 1),
    localparam int NREG       = 2 ** REG_ADDR_W
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [REG_ADDR_W-1:0]                id_rs1_i,
    input  logic [REG_ADDR_W-1:0]                id_rs2_i,
    input  logic                                 id_rs1_used_i,
    input  logic                                 id_rs2_used_i,
    input  logic                                 id_fence_i,
    input  logic [REG_ADDR_W-1:0]                ex_rs1_i,
    input  logic [REG_ADDR_W-1:0]                ex_rs2_i,
    input  logic [NUM_FWD-1:0][REG_ADDR_W-1:0]   fwd_rd_i,
    input  logic [NUM_FWD-1:0]                   fwd_we_i,
    input  logic [NUM_FWD-1:0]                   fwd_rdy_i,
    input  logic                                 mc_issue_i,
    input  logic [REG_ADDR_W-1:0]                mc_issue_rd_i,
    input  logic                                 mc_done_i,
    input  logic [REG_ADDR_W-1:0]                mc_done_rd_i,
    input  logic                                 ex_branch_taken_i,
    output logic [FWD_SEL_W-1:0]                 forward_a_o,
    output logic [FWD_SEL_W-1:0]                 forward_b_o,
    output logic                                 stall_if_o,
    output logic                                 stall_id_o,
    output logic                                 flush_id_o,
    output logic                                 flush_ex_o,
    output logic [NREG-1:0]                      sb_pending_o,
    output logic                                 drain_o,
    output logic [31:0]                          stall_cnt_o,
    output logic [31:0]                          flush_cnt_o
);

    logic [NREG-1:0] sb_eff_s;
    logic            sb_empty_s;
    logic            hazard_s;
    logic            stall_s;
    hazard_state_e   state_q;
    hazard_state_e   state_d;

    hazard_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .issue_i      (mc_issue_i),
        .issue_rd_i   (mc_issue_rd_i),
        .done_i       (mc_done_i),
        .done_rd_i    (mc_done_rd_i),
        .sb_eff_o     (sb_eff_s),
        .sb_pending_o (sb_pending_o),
        .empty_o      (sb_empty_s)
    );

    // Walk from oldest to youngest so the youngest matching source wins.
    function automatic logic [FWD_SEL_W-1:0] fwd_pick(
        input logic [REG_ADDR_W-1:0]               rs,
        input logic [NUM_FWD-1:0]                  we,
        input logic [NUM_FWD-1:0][REG_ADDR_W-1:0]  rd
    );
        logic [FWD_SEL_W-1:0] sel;
        sel = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (we[k] && (rd[k] == rs) && (rs != '0)) begin
                sel = FWD_SEL_W'(k + 1);
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    function automatic logic raw_hit(
        input logic [REG_ADDR_W-1:0]               rs,
        input logic                                used,
        input logic [NREG-1:0]                     sb_eff,
        input logic [NUM_FWD-1:0]                  we,
        input logic [NUM_FWD-1:0][REG_ADDR_W-1:0]  rd,
        input logic [NUM_FWD-1:0]                  rdy
    );
        logic hit;
        hit = sb_eff[rs];
        for (int k = 0; k < NUM_FWD; k++) begin
            if (we[k] && (rd[k] == rs) && !rdy[k]) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit && used && (rs != '0);
    endfunction

    // Forward selects and the decode-stage data hazard.
    always_comb begin
        forward_a_o = fwd_pick(ex_rs1_i, fwd_we_i, fwd_rd_i);
        forward_b_o = fwd_pick(ex_rs2_i, fwd_we_i, fwd_rd_i);
        hazard_s    = raw_hit(id_rs1_i, id_rs1_used_i, sb_eff_s, fwd_we_i, fwd_rd_i, fwd_rdy_i)
                    | raw_hit(id_rs2_i, id_rs2_used_i, sb_eff_s, fwd_we_i, fwd_rd_i, fwd_rdy_i);
    end

    // Fence drain next-state and the combined stall request.
    always_comb begin
        state_d = state_q;
        stall_s = hazard_s;
        case (state_q)
            HZ_RUN: begin
                if (id_fence_i && !sb_empty_s) begin
                    state_d = HZ_DRAIN;
                    stall_s = 1'b1;
                end else begin
                    state_d = HZ_RUN;
                end
            end
            HZ_DRAIN: begin
                if (sb_empty_s || ex_branch_taken_i) begin
                    state_d = HZ_RUN;
                end else begin
                    state_d = HZ_DRAIN;
                end
                if (!sb_empty_s) begin
                    stall_s = 1'b1;
                end else begin
                    stall_s = hazard_s;
                end
            end
            default: begin
                state_d = HZ_RUN;
                stall_s = hazard_s;
            end
        endcase
    end

    // A taken branch squashes the stalled instruction, so it overrides any stall.
    always_comb begin
        stall_if_o = 1'b0;
        stall_id_o = 1'b0;
        flush_id_o = 1'b0;
        flush_ex_o = 1'b0;
        if (ex_branch_taken_i) begin
            flush_id_o = 1'b1;
            flush_ex_o = 1'b1;
        end else if (stall_s) begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
            flush_ex_o = 1'b1;
        end else begin
            flush_ex_o = 1'b0;
        end
    end

    // Fence drain state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= HZ_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign drain_o = (state_q == HZ_DRAIN);

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] flush_cnt_q;
    logic [31:0] flush_cnt_d;

    // Saturating stall/flush event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_id_o) begin
            stall_cnt_d = sat_inc32(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush_id_o) begin
            flush_cnt_d = sat_inc32(flush_cnt_q);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = 32'd0;
    assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed test-plan steps plus random cycles
// against a set-based reference model.
module tb_hazard_ctrl;

    localparam int NF = 2;

    logic             clk;
    logic             rst_ni;
    logic [4:0]       id_rs1, id_rs2;
    logic             id_rs1_used, id_rs2_used, id_fence;
    logic [4:0]       ex_rs1, ex_rs2;
    logic [NF-1:0][4:0] fwd_rd;
    logic [NF-1:0]    fwd_we, fwd_rdy;
    logic             mc_issue, mc_done, br;
    logic [4:0]       mc_issue_rd, mc_done_rd;
    logic [1:0]       fa, fb;
    logic             stall_if, stall_id, flush_id, flush_ex, drain;
    logic [31:0]      sbp, scnt, fcnt;

    bit               pend [32];
    bit               m_drain;
    logic [31:0]      m_scnt, m_fcnt;
    int               cmp_cnt = 0;
    int               err_cnt = 0;

    hazard_ctrl #(.NUM_FWD(NF), .REG_ADDR_W(5)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .id_fence_i(id_fence), .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2),
        .fwd_rd_i(fwd_rd), .fwd_we_i(fwd_we), .fwd_rdy_i(fwd_rdy),
        .mc_issue_i(mc_issue), .mc_issue_rd_i(mc_issue_rd),
        .mc_done_i(mc_done), .mc_done_rd_i(mc_done_rd),
        .ex_branch_taken_i(br),
        .forward_a_o(fa), .forward_b_o(fb),
        .stall_if_o(stall_if), .stall_id_o(stall_id),
        .flush_id_o(flush_id), .flush_ex_o(flush_ex),
        .sb_pending_o(sbp), .drain_o(drain),
        .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_fwd(input logic [4:0] rs);
        for (int k = 0; k < NF; k++)
            if (fwd_we[k] && fwd_rd[k] == rs && rs != 5'd0) return k + 1;
        return 0;
    endfunction

    function automatic bit m_eff(input int r);
        if (r == 0) return 1'b0;
        if (mc_issue && mc_issue_rd == r) return 1'b1;
        if (mc_done && mc_done_rd == r) return 1'b0;
        return pend[r];
    endfunction

    function automatic bit m_busy();
        for (int r = 0; r < 32; r++) if (m_eff(r)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_hit(input logic [4:0] r, input bit used);
        if (!used || r == 5'd0) return 1'b0;
        if (m_eff(int'(r))) return 1'b1;
        for (int k = 0; k < NF; k++)
            if (fwd_we[k] && fwd_rd[k] == r && !fwd_rdy[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        id_fence = 1'b0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
        fwd_rd = '0; fwd_we = 2'b00; fwd_rdy = 2'b00;
        mc_issue = 1'b0; mc_issue_rd = 5'd0; mc_done = 1'b0; mc_done_rd = 5'd0;
        br = 1'b0;
    endtask

    // Check every output against the model, then advance one clock.
    task automatic step();
        bit busy, stall, e_sif, e_sid, e_fid, e_fex;
        logic [31:0] pv;
        bit newp [32];
        #1;
        busy  = m_busy();
        stall = m_hit(id_rs1, id_rs1_used) | m_hit(id_rs2, id_rs2_used)
              | (!m_drain && id_fence && busy) | (m_drain && busy);
        if (br) begin
            e_sif = 1'b0; e_sid = 1'b0; e_fid = 1'b1; e_fex = 1'b1;
        end else if (stall) begin
            e_sif = 1'b1; e_sid = 1'b1; e_fid = 1'b0; e_fex = 1'b1;
        end else begin
            e_sif = 1'b0; e_sid = 1'b0; e_fid = 1'b0; e_fex = 1'b0;
        end
        for (int r = 0; r < 32; r++) pv[r] = pend[r];
        chk("forward_a", 64'(fa), 64'(m_fwd(ex_rs1)));
        chk("forward_b", 64'(fb), 64'(m_fwd(ex_rs2)));
        chk("stall_if", 64'(stall_if), 64'(e_sif));
        chk("stall_id", 64'(stall_id), 64'(e_sid));
        chk("flush_id", 64'(flush_id), 64'(e_fid));
        chk("flush_ex", 64'(flush_ex), 64'(e_fex));
        chk("sb_pending", 64'(sbp), 64'(pv));
        chk("drain", 64'(drain), 64'(m_drain));
        chk("stall_cnt", 64'(scnt), 64'(m_scnt));
        chk("flush_cnt", 64'(fcnt), 64'(m_fcnt));
        if (rst_ni) begin
            for (int r = 0; r < 32; r++) newp[r] = m_eff(r);
            pend = newp;
            if (!m_drain) m_drain = id_fence && busy;
            else          m_drain = busy && !br;
`ifdef HAZARD_PERF_EN
            if (e_sid && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 32'd1;
            if (e_fid && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 32'd1;
`endif
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        for (int r = 0; r < 32; r++) pend[r] = 1'b0;
        m_drain = 1'b0; m_scnt = 32'd0; m_fcnt = 32'd0;
        step();
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0;
        idle();
        @(negedge clk);
        do_reset();
        step();

        // Forwarding: youngest wins, x0 never forwarded, no match selects regfile.
        fwd_we = 2'b11; fwd_rdy = 2'b11; fwd_rd[0] = 5'd5; fwd_rd[1] = 5'd5; ex_rs1 = 5'd5;
        #1 chk("plan_fwd_hit", 64'(fa), 64'd1);
        step();
        ex_rs1 = 5'd0;
        #1 chk("plan_fwd_x0", 64'(fa), 64'd0);
        step();
        ex_rs1 = 5'd6;
        #1 chk("plan_fwd_nomatch", 64'(fa), 64'd0);
        step();

        // Load-use: one stall cycle, then forwarded from source 0.
        idle();
        fwd_we[0] = 1'b1; fwd_rd[0] = 5'd7; fwd_rdy[0] = 1'b0; id_rs2 = 5'd7; id_rs2_used = 1'b1;
        #1 chk("plan_loaduse_stall", 64'({stall_if, stall_id, flush_ex}), 64'b111);
        step();
        fwd_rdy[0] = 1'b1; ex_rs2 = 5'd7;
        #1 chk("plan_loaduse_release", 64'({stall_id, fb}), 64'({1'b0, 2'd1}));
        step();

        // Multi-cycle rd=9: stall until done, released in the done cycle.
        idle(); mc_issue = 1'b1; mc_issue_rd = 5'd9; step();
        idle(); id_rs1 = 5'd9; id_rs1_used = 1'b1;
        #1 chk("plan_sb9_set", 64'(sbp[9]), 64'd1);
        step(); step();
        mc_done = 1'b1; mc_done_rd = 5'd9;
        #1 chk("plan_sb9_release", 64'(stall_id), 64'd0);
        step();
        idle(); step();

        // Fence drain ended by completion.
        mc_issue = 1'b1; mc_issue_rd = 5'd3; step();
        idle(); id_fence = 1'b1; step(); step();
        #1 chk("plan_drain_on", 64'(drain), 64'd1);
        mc_done = 1'b1; mc_done_rd = 5'd3; step();
        idle(); id_fence = 1'b1; step();
        idle(); step();

        // Fence drain ended by a taken branch.
        mc_issue = 1'b1; mc_issue_rd = 5'd3; step();
        idle(); id_fence = 1'b1; step(); step();
        br = 1'b1;
        #1 chk("plan_drain_branch", 64'({flush_id, flush_ex, stall_id}), 64'b110);
        step();
        idle(); step();
        mc_done = 1'b1; mc_done_rd = 5'd3; step();

        // Same-rd set and clear in one cycle: set wins.
        idle(); mc_issue = 1'b1; mc_issue_rd = 5'd4; step();
        mc_done = 1'b1; mc_done_rd = 5'd4; step();
        idle();
        #1 chk("plan_set_wins", 64'(sbp[4]), 64'd1);
        step();
        mc_done = 1'b1; mc_done_rd = 5'd4; step();

        // Branch during load-use hazard.
        idle(); fwd_we[0] = 1'b1; fwd_rd[0] = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b1; br = 1'b1;
        step();

        // Counter scenario: 3 stalls then 1 flush from a clean reset.
        idle(); do_reset();
        fwd_we[0] = 1'b1; fwd_rd[0] = 5'd8; id_rs1 = 5'd8; id_rs1_used = 1'b1;
        step(); step(); step();
        idle(); br = 1'b1; step();
        idle();
`ifdef HAZARD_PERF_EN
        #1 chk("plan_perf", 64'({scnt, fcnt}), {32'd3, 32'd1});
`else
        #1 chk("plan_perf_off", 64'({scnt, fcnt}), 64'd0);
`endif
        step();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
            id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
            id_fence = ($urandom_range(0, 7) == 0);
            ex_rs1 = 5'($urandom_range(0, 7)); ex_rs2 = 5'($urandom_range(0, 7));
            for (int k = 0; k < NF; k++) fwd_rd[k] = 5'($urandom_range(0, 7));
            fwd_we = 2'($urandom); fwd_rdy = 2'($urandom);
            mc_issue = ($urandom_range(0, 2) == 0); mc_issue_rd = 5'($urandom_range(0, 7));
            mc_done = ($urandom_range(0, 1) == 0); mc_done_rd = 5'($urandom_range(0, 7));
            br = ($urandom_range(0, 9) == 0);
            step();
        end

        // Reset in the middle of a drain.
        idle(); mc_issue = 1'b1; mc_issue_rd = 5'd3; step();
        idle(); id_fence = 1'b1; step(); step();
        idle(); do_reset();
        #1 chk("plan_reset_mid_drain", 64'({drain, sbp}), 64'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
